// File: rtl/adder_2_share_ctrl.sv
// Round-robin time-share of one external combinational 3-bit adder (adder_2 pin set) among NREQ requesters.
// Latency accept->rsp_valid = SETTLE+1; rsp held until rsp_ready; macro APPROX_ERR_MON_EN adds err_cnt/err_dist.
module adder_2_share_ctrl #(
    parameter int  NREQ   = 4,
    parameter int  SETTLE = 1,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*7-1:0] req_opnd,
    output logic [6:0]        add_pi,
    input  logic [3:0]        add_po,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_sum,
    output logic              busy
`ifdef APPROX_ERR_MON_EN
    ,
    output logic [15:0]       err_cnt,
    output logic [19:0]       err_dist
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, DRIVE, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] win_q, win_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [6:0]     add_pi_q, add_pi_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [3:0]     rsp_sum_q, rsp_sum_d;
    logic [1:0]     rst_sync_q, rst_sync_d;
    logic           arst_n;
    logic           capture;
    logic [IDW-1:0] pick_id;
    logic           pick_vld;
    logic [6:0]     sel_opnd;

    // Reset asserts immediately, releases two clocks after rst_n rises.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign arst_n = rst_sync_q[1];

    function automatic logic [IDW-1:0] idx_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    // Scan downward so the smallest offset from rr_ptr wins.
    always_comb begin
        pick_id  = '0;
        pick_vld = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req_valid[idx_add(rr_ptr_q, off)]) begin
                pick_id  = idx_add(rr_ptr_q, off);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_opnd  = 7'd0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == IDW'(i)) begin
                sel_opnd     = req_opnd[i*7 +: 7];
                req_ready[i] = (state_q == GRANT);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        add_pi_d    = add_pi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    win_d   = pick_id;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                add_pi_d = sel_opnd;
                cnt_d    = 4'(SETTLE - 1);
                state_d  = DRIVE;
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = idx_add(win_q, 1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            rsp_sum_d   = add_po;
            rsp_id_d    = win_q;
            rsp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            win_q       <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= 4'd0;
            add_pi_q    <= 7'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            add_pi_q    <= add_pi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign add_pi    = add_pi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != IDLE);

`ifdef APPROX_ERR_MON_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [19:0] err_dist_q, err_dist_d;
    logic [3:0]  exact_sum;
    logic [3:0]  abs_diff;
    logic [20:0] dist_sum;

    // add_pi_q is stable through DRIVE, so the exact reference is valid at capture.
    always_comb begin
        exact_sum  = {1'b0, add_pi_q[2:0]} + {1'b0, add_pi_q[5:3]} + {3'b000, add_pi_q[6]};
        abs_diff   = (add_po >= exact_sum) ? (add_po - exact_sum) : (exact_sum - add_po);
        dist_sum   = {1'b0, err_dist_q} + {17'd0, abs_diff};
        err_cnt_d  = err_cnt_q;
        err_dist_d = err_dist_q;
        if (capture && (abs_diff != 4'd0)) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            err_dist_d = dist_sum[20] ? 20'hFFFFF : dist_sum[19:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_cnt_q  <= 16'd0;
            err_dist_q <= 20'd0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_dist_q <= err_dist_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_dist = err_dist_q;
`endif

endmodule

// File: tb/tb_adder_2_share_ctrl.sv
// Bench for adder_2_share_ctrl: transaction-timeline model plus directed literal checks and random traffic.
module tb_adder_2_share_ctrl;
    localparam int NREQ   = 4;
    localparam int SETTLE = 1;
    localparam int IDW    = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*7-1:0] req_opnd;
    logic [6:0]        add_pi;
    logic [3:0]        add_po;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_sum;
    logic              busy;
`ifdef APPROX_ERR_MON_EN
    logic [15:0]       err_cnt;
    logic [19:0]       err_dist;
`endif

    int amode; // external adder: 0 exact, 1 lsb flipped, 2 coarse approximation

    function automatic logic [3:0] adder_fn(input logic [6:0] pi, input int mode);
        int a, b, ci, s;
        a  = int'(pi[2:0]);
        b  = int'(pi[5:3]);
        ci = int'(pi[6]);
        s  = a + b + ci;
        if (mode == 1)      s = s ^ 1;
        else if (mode == 2) s = (((a >> 1) + (b >> 1)) * 2) | ((a | b) & 1);
        return 4'(s);
    endfunction

    assign add_po = adder_fn(add_pi, amode);

    always #5 clk = ~clk;

    adder_2_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opnd(req_opnd),
        .add_pi(add_pi), .add_po(add_po),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .busy(busy)
`ifdef APPROX_ERR_MON_EN
        , .err_cnt(err_cnt), .err_dist(err_dist)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: one op at a time, described by its decision cycle and winner.
    bit            m_act;
    int            m_start, m_win, m_ptr;
    logic [6:0]    m_opnd, m_pi;
    logic [3:0]    m_sum;
    int            m_err_cnt, m_err_dist;
    logic [NREQ-1:0] acc;
    int            gq_id[$];
    int            gq_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_start = 0; m_win = 0; m_ptr = 0;
        m_opnd = 7'd0; m_pi = 7'd0; m_sum = 4'd0;
        m_err_cnt = 0; m_err_dist = 0; acc = '0;
    endtask

    // Applies the inputs that the coming rising edge will sample.
    task automatic model_advance();
        int k, ex, d;
        if (!rst_n) return;
        if (!m_act) begin
            if (req_valid != '0) begin
                m_act = 1; m_start = cyc; m_win = -1;
                for (int off = 0; off < NREQ; off++)
                    if (m_win < 0 && req_valid[(m_ptr + off) % NREQ]) m_win = (m_ptr + off) % NREQ;
            end
        end else begin
            k = cyc - m_start;
            if (k == 1) begin
                chk("valid_held", {31'd0, req_valid[m_win]}, 32'd1);
                m_opnd = req_opnd[m_win*7 +: 7];
                m_pi = m_opnd;
                acc[m_win] = 1'b1;
            end
            if (k == SETTLE + 1) begin
                m_sum = adder_fn(m_opnd, amode);
                ex = int'(m_opnd[2:0]) + int'(m_opnd[5:3]) + int'(m_opnd[6]);
                d = (int'(m_sum) > ex) ? int'(m_sum) - ex : ex - int'(m_sum);
                if (d != 0) begin
                    if (m_err_cnt < 65535) m_err_cnt++;
                    m_err_dist = (m_err_dist + d > 20'hFFFFF) ? 20'hFFFFF : m_err_dist + d;
                end
            end
            if (k >= SETTLE + 2 && rsp_ready) begin
                m_act = 0;
                m_ptr = (m_win + 1) % NREQ;
            end
        end
    endtask

    task automatic check();
        logic [NREQ-1:0] exp_rdy;
        bit exp_rv;
        int id;
        exp_rdy = '0;
        exp_rv = 0;
        if (m_act) begin
            if (cyc - m_start == 1) exp_rdy[m_win] = 1'b1;
            if (cyc - m_start >= SETTLE + 2) exp_rv = 1;
        end
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        chk("busy", {31'd0, busy}, {31'd0, m_act});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
        chk("add_pi", {25'd0, add_pi}, {25'd0, m_pi});
        if (exp_rv) begin
            chk("rsp_id", {{(32-IDW){1'b0}}, rsp_id}, 32'(m_win));
            chk("rsp_sum", {28'd0, rsp_sum}, {28'd0, m_sum});
        end
`ifdef APPROX_ERR_MON_EN
        chk("err_cnt", {16'd0, err_cnt}, 32'(m_err_cnt));
        chk("err_dist", {12'd0, err_dist}, 32'(m_err_dist));
`endif
        if (req_ready != '0) begin
            id = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
            gq_id.push_back(id);
            gq_cyc.push_back(cyc);
        end
    endtask

    task automatic tick();
        model_advance();
        @(negedge clk);
        cyc++;
        check();
    endtask

    task automatic consume(input bit keep);
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                acc[i] = 1'b0;
                if (keep) req_opnd[i*7 +: 7] = 7'($urandom);
                else      req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic quiesce();
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    acc[i] = 1'b0;
                end else if (!(m_act && (cyc - m_start) == 1 && m_win == i)) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 1'b1;
            if (!m_act && req_valid == '0) break;
            tick();
        end
        chk("quiesce_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
        chk({tag, "_add_pi"}, {25'd0, add_pi}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_id"}, {{(32-IDW){1'b0}}, rsp_id}, 32'd0);
        chk({tag, "_rsp_sum"}, {28'd0, rsp_sum}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int g, r, found;
        logic [IDW-1:0] hold_id;
        logic [3:0] hold_sum;
        rst_n = 1'b0; req_valid = '0; req_opnd = '0; rsp_ready = 1'b0; amode = 0;
        model_reset();
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (4) tick();

        // All requesters valid continuously: grants rotate 0,1,2,3,0 every SETTLE+3 cycles.
        gq_id.delete(); gq_cyc.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_opnd[i*7 +: 7] = 7'($urandom);
        req_valid = '1;
        for (int n = 0; n < 30 && gq_id.size() < 5; n++) begin consume(1'b1); tick(); end
        chk("t3_count", 32'(gq_id.size() >= 5), 32'd1);
        for (int j = 0; j < 5; j++)
            chk("t3_order", (j < gq_id.size()) ? 32'(gq_id[j]) : 32'hFFFF, 32'(j % 4));
        for (int j = 0; j < 4; j++)
            chk("t3_period", (j + 1 < gq_cyc.size()) ? 32'(gq_cyc[j+1] - gq_cyc[j]) : 32'd0, 32'd4);
        quiesce();

        // Single op on req0: a=3, b=2, cin=1 through an exact adder.
        g = -100;
        req_opnd[6:0] = 7'b1010011;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            consume(1'b0);
            tick();
            if (req_ready[0]) g = cyc;
            if (cyc == g + 1) begin
                chk("t2_add_pi", {25'd0, add_pi}, 32'b1010011);
                chk("t2_rsp_early", {31'd0, rsp_valid}, 32'd0);
            end
            if (cyc == g + 2) begin
                chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("t2_rsp_id", {{(32-IDW){1'b0}}, rsp_id}, 32'd0);
                chk("t2_rsp_sum", {28'd0, rsp_sum}, 32'd6);
            end
        end
        chk("t2_granted", 32'(g >= 0), 32'd1);
        quiesce();

        // Response backpressure for 5 cycles while others wait.
        rsp_ready = 1'b0;
        for (int i = 1; i < NREQ; i++) begin req_valid[i] = 1'b1; req_opnd[i*7 +: 7] = 7'($urandom); end
        for (int n = 0; n < 20 && !rsp_valid; n++) begin consume(1'b1); rsp_ready = 1'b0; tick(); end
        chk("t4_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        hold_id = rsp_id; hold_sum = rsp_sum;
        for (int n = 0; n < 5; n++) begin
            consume(1'b1); rsp_ready = 1'b0; tick();
            chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t4_hold_id", {{(32-IDW){1'b0}}, rsp_id}, {{(32-IDW){1'b0}}, hold_id});
            chk("t4_hold_sum", {28'd0, rsp_sum}, {28'd0, hold_sum});
            chk("t4_no_ready", {28'd0, req_ready}, 32'd0);
        end
        gq_id.delete(); gq_cyc.delete();
        for (int n = 0; n < 6; n++) begin consume(1'b1); rsp_ready = 1'b1; tick(); end
        chk("t4_resumed", 32'(gq_id.size() >= 1), 32'd1);
        quiesce();

        // Move rr_ptr to 2 via req1, then req1 and req3 together: 3 wins, then 1.
        req_valid[1] = 1'b1; req_opnd[7 +: 7] = 7'($urandom);
        tick();
        quiesce();
        gq_id.delete(); gq_cyc.delete();
        req_opnd[7 +: 7] = 7'($urandom); req_opnd[21 +: 7] = 7'($urandom);
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        for (int n = 0; n < 16; n++) begin consume(1'b0); tick(); end
        chk("t5_count", 32'(gq_id.size()), 32'd2);
        chk("t5_first", (gq_id.size() > 0) ? 32'(gq_id[0]) : 32'hFFFF, 32'd3);
        chk("t5_second", (gq_id.size() > 1) ? 32'(gq_id[1]) : 32'hFFFF, 32'd1);
        quiesce();

        // Reset in the middle of DRIVE: everything clears, no response follows.
        found = 0;
        req_valid[2] = 1'b1; req_opnd[14 +: 7] = 7'($urandom);
        for (int n = 0; n < 10 && found == 0; n++) begin
            consume(1'b0); tick();
            if (m_act && cyc - m_start == 2) found = 1;
        end
        chk("rst_reached_drive", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();

`ifdef APPROX_ERR_MON_EN
        chk("err_cnt_exact", {16'd0, err_cnt}, 32'd0);
        chk("err_dist_exact", {12'd0, err_dist}, 32'd0);
`endif
        // Ten ops through an adder whose sum has the lsb flipped.
        amode = 1;
        for (int j = 0; j < 10; j++) begin
            r = int'($urandom_range(NREQ - 1));
            req_valid[r] = 1'b1; req_opnd[r*7 +: 7] = 7'($urandom);
            tick();
            quiesce();
        end
`ifdef APPROX_ERR_MON_EN
        chk("t6_err_cnt", {16'd0, err_cnt}, 32'd10);
        chk("t6_err_dist", {12'd0, err_dist}, 32'd10);
`endif
        amode = 0;

        // Random traffic with random response backpressure and adder behaviour.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 2) amode = int'($urandom_range(2));
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin req_valid[i] = 1'b0; acc[i] = 1'b0; end
                if (!req_valid[i] && $urandom_range(99) < 30) begin
                    req_valid[i] = 1'b1;
                    req_opnd[i*7 +: 7] = 7'($urandom);
                end
            end
            rsp_ready = ($urandom_range(99) < 70);
            tick();
        end
        quiesce();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
